// File: rtl/ysyx_24100005_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100005_pkg
//  Description : Shared types and constants for the NPC instruction fetch
//                unit: fetch FSM state encoding, instruction width, reset PC
//                and the NOP word shown while no instruction is valid.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24100005_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

endpackage : ysyx_24100005_pkg
`default_nettype wire

// File: rtl/ysyx_24100005_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100005_pc_reg
//  Description : Architectural PC register. A redirect always wins over the
//                sequential +4 step; the adder wraps at 32 bits.
//  Ports       : clk            - clock, rising edge
//                rst            - synchronous reset, active low
//                redirect_valid - load redirect_pc this cycle
//                redirect_pc    - redirect target
//                advance        - step to pc + 4 this cycle
//                pc             - current PC
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100005_pc_reg
  import ysyx_24100005_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_VAL = RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [INST_W-1:0] redirect_pc,
  input  logic              advance,
  output logic [INST_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_VAL;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (advance) begin
      pc <= pc + INST_W'(4);
    end
  end

endmodule : ysyx_24100005_pc_reg
`default_nettype wire

// File: rtl/ysyx_24100005_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100005_ifu
//  Description : Instruction fetch unit. Owns the PC, issues one word fetch
//                at a time on a request/response port, presents the result
//                with its PC through a valid/ready handshake and accepts
//                redirects at any time, discarding fetches they make stale.
//  Ports       : clk, rst          - clock / synchronous active-low reset
//                req_valid/ready   - fetch request handshake
//                req_addr          - fetch address (word aligned)
//                rsp_valid/data    - fetch response
//                out_valid/ready   - downstream instruction handshake
//                out_inst/out_pc   - instruction and its PC
//                redirect_valid/pc - PC redirect pulse and target
//                out_fault         - misaligned-target flag (option only)
//  Options     : YSYX_24100005_IFU_MISALIGN_CHK_EN - when defined, a
//                misaligned redirect target is reported on out_fault instead
//                of being fetched; otherwise the target's low bits are
//                forced to zero and out_fault does not exist.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100005_ifu #(
  parameter logic [ysyx_24100005_pkg::INST_W-1:0] RESET_PC = ysyx_24100005_pkg::RESET_PC,
  parameter logic [ysyx_24100005_pkg::INST_W-1:0] NOP_INST = ysyx_24100005_pkg::NOP_INST
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  req_valid,
  input  logic                                  req_ready,
  output logic [ysyx_24100005_pkg::INST_W-1:0]  req_addr,
  input  logic                                  rsp_valid,
  input  logic [ysyx_24100005_pkg::INST_W-1:0]  rsp_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ysyx_24100005_pkg::INST_W-1:0]  out_inst,
  output logic [ysyx_24100005_pkg::INST_W-1:0]  out_pc,
  input  logic                                  redirect_valid,
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
  output logic                                  out_fault,
`endif
  input  logic [ysyx_24100005_pkg::INST_W-1:0]  redirect_pc
);

  import ysyx_24100005_pkg::*;

  ifu_state_e        state, state_next;
  logic              drop, drop_next;
  logic [INST_W-1:0] inst_q, inst_next;
  logic [INST_W-1:0] opc_q, opc_next;
  logic [INST_W-1:0] pc;
  logic [INST_W-1:0] target;
  logic              advance;
  logic              fault, fault_next;

`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
  logic misalign;
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign target   = redirect_pc;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign target              = {redirect_pc[INST_W-1:2], 2'b00};
`endif

  // A faulted HOLD parks the PC until the next redirect.
  assign advance = (state == HOLD) && out_ready && !fault;

  ysyx_24100005_pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (target),
    .advance        (advance),
    .pc             (pc)
  );

  always_comb begin
    state_next = state;
    drop_next  = drop;
    inst_next  = inst_q;
    opc_next   = opc_q;
    fault_next = fault;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (req_ready) begin
          state_next = WAIT;
          // The accepted request carries the old address: its data is stale.
          if (redirect_valid) drop_next = 1'b1;
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          if (drop || redirect_valid) begin
            drop_next  = 1'b0;
            state_next = REQ;
          end else begin
            inst_next  = rsp_data;
            opc_next   = pc;
            state_next = HOLD;
          end
        end else if (redirect_valid) begin
          drop_next = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid || (out_ready && !fault)) begin
          state_next = REQ;
          inst_next  = NOP_INST;
          fault_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
    // Misaligned target: report it directly, never fetch it. Any response
    // still in flight lands outside WAIT and is ignored, so drop is cleared.
    if (misalign) begin
      state_next = HOLD;
      drop_next  = 1'b0;
      inst_next  = NOP_INST;
      opc_next   = target;
      fault_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      drop   <= 1'b0;
      inst_q <= NOP_INST;
      opc_q  <= '0;
      fault  <= 1'b0;
    end else begin
      state  <= state_next;
      drop   <= drop_next;
      inst_q <= inst_next;
      opc_q  <= opc_next;
      fault  <= fault_next;
    end
  end

  assign req_valid = (state == REQ);
  assign req_addr  = pc;
  assign out_valid = (state == HOLD);
  assign out_inst  = inst_q;
  assign out_pc    = opc_q;
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
  assign out_fault = fault;
`endif

endmodule : ysyx_24100005_ifu
`default_nettype wire

// File: tb/tb_ysyx_24100005_ifu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24100005_ifu
//  Description : Self-checking bench for ysyx_24100005_ifu. A reference
//                model tracks the architectural PC from reset, redirects and
//                consumed instructions; a memory model answers fetches with
//                an address-derived word so stale data is detectable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100005_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        req_valid, out_valid;
  logic [31:0] req_addr, out_inst, out_pc;
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
  logic        out_fault;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_24100005_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
    .out_fault      (out_fault),
`endif
    .redirect_pc    (redirect_pc)
  );

  // Memory contents: the reset-vector word is fixed, every other word is a
  // distinct function of its address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == RST_PC) return 32'h0000_0093;
    return {a[31:2], 2'b11} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------- memory
  logic        mem_rand = 1'b0;
  int          mem_lat  = 1;
  logic        inject   = 1'b0;
  logic        busy     = 1'b0;
  int          cnt      = 0;
  logic [31:0] maddr    = 32'h0;

  initial begin
    logic        acc;
    logic        rst_s;
    logic [31:0] acc_addr;
    forever begin
      @(negedge clk);
      rst_s    = rst;
      acc      = rst && req_valid && req_ready;
      acc_addr = req_addr;
      @(posedge clk);
      #2;
      rsp_valid = 1'b0;
      if (!rst_s) busy = 1'b0;
      if (acc) begin
        busy  = 1'b1;
        maddr = acc_addr;
        cnt   = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
      end
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = mem_fn(maddr);
          busy      = 1'b0;
        end
      end else if (inject) begin
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // ------------------------------------------------- model + compare
  logic [31:0] mpc    = RST_PC;
  logic        mfault = 1'b0;

  initial begin
    logic armed    = 1'b0;
    logic rst_prev = 1'b1;
    int   idle     = 0;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (!rst_prev) begin
          chk1("rst_req_valid", req_valid, 1'b0);
          chk1("rst_out_valid", out_valid, 1'b0);
          chk("rst_out_pc", out_pc, 32'h0);
        end
        if (out_valid) begin
          chk("out_pc", out_pc, mpc);
          chk("out_inst", out_inst, mfault ? NOP : mem_fn(mpc));
        end else begin
          chk("idle_inst", out_inst, NOP);
        end
        if (req_valid) chk("req_addr", req_addr, mpc);
        chk1("valid_excl", req_valid & out_valid, 1'b0);
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
        chk1("out_fault", out_fault, mfault);
`endif
        idle = (req_valid || out_valid || !rst) ? 0 : idle + 1;
        if (idle > 16) begin
          chk("watchdog_idle_cycles", idle, 0);
          idle = 0;
        end
      end
      // Architectural PC for the cycle after the coming edge.
      if (!rst) begin
        mpc    = RST_PC;
        mfault = 1'b0;
      end else if (redirect_valid) begin
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
        mpc    = redirect_pc;
        mfault = (redirect_pc[1:0] != 2'b00);
`else
        mpc    = redirect_pc & ~32'd3;
`endif
      end else if (out_valid && out_ready && !mfault) begin
        mpc = mpc + 32'd4;
      end
      rst_prev = rst;
      if (!rst) armed = 1'b1;
    end
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    logic seen;
    int   k;
    int   n_hs;
    rst       = 1'b0;
    req_ready = 1'b1;
    out_ready = 1'b0;
    mem_lat   = 1;
    step(3);
    chk1("t0_req_valid", req_valid, 1'b0);
    chk1("t0_out_valid", out_valid, 1'b0);
    chk("t0_out_inst", out_inst, NOP);
    chk("t0_out_pc", out_pc, 32'h0);

    // First fetch after release.
    rst = 1'b1;
    step(1);
    chk1("t1_req_valid", req_valid, 1'b1);
    chk("t1_req_addr", req_addr, 32'h8000_0000);
    step(1);
    chk1("t1_wait_req", req_valid, 1'b0);
    step(1);
    chk1("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_inst", out_inst, 32'h0000_0093);
    chk("t1_out_pc", out_pc, 32'h8000_0000);

    // Backpressure in HOLD.
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk1("t2_hold_valid", out_valid, 1'b1);
      chk("t2_hold_inst", out_inst, 32'h0000_0093);
      chk("t2_hold_pc", out_pc, 32'h8000_0000);
      chk1("t2_no_req", req_valid, 1'b0);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk1("t2_req_valid", req_valid, 1'b1);
    chk("t2_req_addr", req_addr, 32'h8000_0004);

    // Redirect during WAIT; old response arrives afterwards.
    mem_lat = 3;
    step(1);
    chk1("t3_in_wait", req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    step(1);
    redirect_valid = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!req_valid && k < 12) begin
      step(1);
      if (out_valid) seen = 1'b1;
      k++;
    end
    chk1("t3_no_stale_out", seen, 1'b0);
    chk1("t3_req_valid", req_valid, 1'b1);
    chk("t3_req_addr", req_addr, 32'h8000_0100);

    // Redirect in the same cycle the request is accepted.
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step(1);
    redirect_valid = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!req_valid && k < 12) begin
      step(1);
      if (out_valid) seen = 1'b1;
      k++;
    end
    chk1("t4_no_stale_out", seen, 1'b0);
    chk("t4_req_addr", req_addr, 32'h8000_0200);
    k = 0;
    while (!out_valid && k < 12) begin
      step(1);
      k++;
    end
    chk1("t4_out_valid", out_valid, 1'b1);
    chk("t4_out_pc", out_pc, 32'h8000_0200);
    chk("t4_out_inst", out_inst, 32'h8F0F_0203);

    // Reset during WAIT, spurious response right after release.
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    mem_lat   = 4;
    step(2);
    rst = 1'b0;
    step(2);
    chk1("t5_req_valid", req_valid, 1'b0);
    chk1("t5_out_valid", out_valid, 1'b0);
    chk("t5_out_inst", out_inst, NOP);
    chk("t5_out_pc", out_pc, 32'h0);
    rst    = 1'b1;
    inject = 1'b1;
    step(1);
    inject = 1'b0;
    chk1("t5_req_valid_rel", req_valid, 1'b1);
    chk("t5_req_addr", req_addr, 32'h8000_0000);
    mem_lat = 1;
    k = 0;
    while (!out_valid && k < 12) begin
      step(1);
      k++;
    end
    chk("t5_out_inst", out_inst, 32'h0000_0093);
    chk("t5_out_pc", out_pc, 32'h8000_0000);

`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step(1);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk1("t6_out_valid", out_valid, 1'b1);
      chk1("t6_out_fault", out_fault, 1'b1);
      chk("t6_out_pc", out_pc, 32'h8000_0102);
      chk1("t6_no_req", req_valid, 1'b0);
      step(1);
    end
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    step(1);
    redirect_valid = 1'b0;
    chk("t6_recover_addr", req_addr, 32'h8000_0300);
`endif

    // Randomized traffic against the model.
    mem_rand = 1'b1;
    n_hs     = 0;
    for (int i = 0; i < 3000; i++) begin
      req_ready      = ($urandom % 4) != 0;
      out_ready      = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 12) == 0;
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
      redirect_pc    = 32'h8000_0000 | (($urandom % 1024) << 2);
`else
      redirect_pc    = 32'h8000_0000 | (($urandom % 1024) << 2) | ($urandom % 4);
`endif
      if (out_valid && out_ready) n_hs++;
      step(1);
    end
    redirect_valid = 1'b0;
    chk1("rand_progress", n_hs > 100, 1'b1);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ysyx_24100005_ifu
`default_nettype wire

// File: doc/ysyx_24100005_ifu.md
# ysyx_24100005_ifu

Instruction fetch unit for the NPC core. It owns the architectural PC and issues one word-aligned fetch at a time on a simple request/response memory port. It presents each fetched instruction with its PC to the downstream execute stage (`ysyx_24100005_top`) through a valid/ready handshake. It also accepts PC redirects (branch/jump/trap) from downstream at any time and discards any fetch made stale by a redirect.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset.
- `NOP_INST`, default 32'h0000_0013: value held on `out_inst` while no instruction is valid.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  out  1  fetch request valid.
- `req_ready`  in  1  memory accepts the request this cycle.
- `req_addr`  out  32  fetch address, always word-aligned.
- `rsp_valid`  in  1  response data valid.
- `rsp_data`  in  32  fetched instruction word.
- `out_valid`  out  1  instruction available to downstream.
- `out_ready`  in  1  downstream consumes the instruction this cycle.
- `out_inst`  out  32  instruction word.
- `out_pc`  out  32  PC of `out_inst`.
- `redirect_valid`  in  1  load a new PC; single-cycle pulse.
- `redirect_pc`  in  32  target PC.
- `out_fault`  out  1  misaligned-target fault flag (present only with `YSYX_24100005_IFU_MISALIGN_CHK_EN`).

## Operation
- State machine states: IDLE, REQ, WAIT, HOLD. There is also a 1-bit `drop` flag.
- Reset (`rst`=0 at a clock edge) sets:
  - state=IDLE, pc=`RESET_PC`, drop=0
  - `req_valid`=0, `out_valid`=0, `out_inst`=`NOP_INST`, `out_pc`=0, `out_fault`=0
- Reset takes effect in any state. An in-flight response arriving after reset is ignored.
- IDLE → REQ unconditionally.
- REQ: `req_valid`=1 and `req_addr`=pc.
  - `req_ready`=1 → WAIT.
  - Otherwise stay in REQ.
- WAIT: on `rsp_valid`=1:
  - If drop=1: clear drop, discard the data, go to REQ.
  - If drop=0: latch `out_inst`=`rsp_data` and `out_pc`=pc, go to HOLD.
- HOLD: `out_valid`=1, and `out_inst`/`out_pc` are stable.
  - On `out_ready`=1: pc ← pc+4 (32-bit wrap, 0xFFFF_FFFC+4 = 0), go to REQ.
- Redirect has priority over pc+4 in every state. Behaviour on `redirect_valid`=1:
  - IDLE: pc ← target.
  - REQ without acceptance: pc ← target, stay in REQ. `req_addr` changes next cycle; the memory port permits address change while unaccepted.
  - REQ with `req_ready`=1 in the same cycle: request leaves with the old address; pc ← target, drop=1, go to WAIT.
  - WAIT: pc ← target, drop=1. If `rsp_valid`=1 in the same cycle, that response is discarded and state goes to REQ with drop=0.
  - HOLD: pc ← target, `out_valid` falls next cycle, go to REQ. A simultaneous `out_ready` completes the handshake, and the redirect still sets the next PC.
- `rsp_valid` outside WAIT is ignored.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Best case (`req_ready`=1, response one cycle after acceptance, `out_ready`=1): 3 cycles per instruction.
- After reset release, the first `req_valid` is asserted 1 cycle later and the first `out_valid` at the earliest 3 cycles later.
- A redirect asserted in cycle N puts the target on `req_addr` no later than the first REQ cycle after N. A stale instruction is never presented after cycle N.

## Configuration
- `YSYX_24100005_IFU_MISALIGN_CHK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 skips the fetch and goes directly to HOLD.
  - In that HOLD: `out_fault`=1, `out_inst`=`NOP_INST`, `out_pc`=target.
  - pc then stays unchanged until the next redirect.
- Undefined:
  - `out_fault` port is absent.
  - `redirect_pc[1:0]` is forced to 0.

## Structure
- Shared package `ysyx_24100005_pkg` holds:
  - the state enum typedef
  - `RESET_PC` and `NOP_INST` constants
  - the `INST_W`=32 width constant
- One sub-module, `ysyx_24100005_pc_reg`: PC register with synchronous active-low reset, redirect mux, and +4 adder.

## Test plan
- Reset held 3 cycles, then released with `req_ready`=1 and 1-cycle response latency returning 0x00000093 → `req_addr`=0x8000_0000; `out_valid`=1 with `out_inst`=0x00000093 and `out_pc`=0x8000_0000 three cycles after release.
- `out_ready` held low 5 cycles in HOLD → `out_inst`/`out_pc` stable, no new `req_valid`; on `out_ready`=1 the next `req_addr`=0x8000_0004.
- Redirect to 0x8000_0100 during WAIT, old response then arrives → old response never appears on `out_valid`; next `req_addr`=0x8000_0100.
- Redirect to 0x8000_0200 in the same cycle as REQ acceptance → one response dropped; the following fetch uses 0x8000_0200.
- `rst` asserted low during WAIT, `rsp_valid` pulses after release → all outputs at reset values; first fetch goes to 0x8000_0000.
- With the macro defined, redirect to 0x8000_0102 → `out_valid`=1, `out_fault`=1, `out_pc`=0x8000_0102, no `req_valid` issued.
